// File: rtl/yuv_to_rgb_stream.sv
// yuv_to_rgb_stream: LANES-wide YUV->RGB converter in a 3-stage valid/ready pipeline with frame tracking.
// Define YUV2RGB_FULL_RANGE_EN to add a per-beat full_range input that selects full-range coefficients.
module yuv_to_rgb_stream #(
  parameter int DW    = 8,
  parameter int LANES = 2,
  parameter int W     = 320,
  parameter int H     = 240,
  parameter int CW    = 18
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_y,
  input  logic [LANES*DW-1:0] in_u,
  input  logic [LANES*DW-1:0] in_v,
`ifdef YUV2RGB_FULL_RANGE_EN
  input  logic                full_range,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_r,
  output logic [LANES*DW-1:0] out_g,
  output logic [LANES*DW-1:0] out_b,
  output logic                out_last,
  output logic                frame_done,
  output logic [CW-1:0]       pix_cnt
);
  localparam int K  = DW - 8;
  localparam int XW = DW + 2;
  localparam int AW = DW + 21;

  localparam logic signed [XW-1:0] Y_OFS = XW'(16 << K);
  localparam logic signed [XW-1:0] C_OFS = XW'(128 << K);

  // Studio-range gains (16.16)
  localparam logic signed [AW-1:0] CS_Y  = AW'(76284);
  localparam logic signed [AW-1:0] CS_RV = AW'(104595);
  localparam logic signed [AW-1:0] CS_GU = AW'(-25624);
  localparam logic signed [AW-1:0] CS_GV = AW'(-53281);
  localparam logic signed [AW-1:0] CS_BU = AW'(132251);
  // Full-range gains (16.16)
  localparam logic signed [AW-1:0] CF_Y  = AW'(65536);
  localparam logic signed [AW-1:0] CF_RV = AW'(91881);
  localparam logic signed [AW-1:0] CF_GU = AW'(-22554);
  localparam logic signed [AW-1:0] CF_GV = AW'(-46802);
  localparam logic signed [AW-1:0] CF_BU = AW'(116130);

  localparam logic [CW-1:0] LAST_CNT = CW'(W * H - LANES);
  localparam logic [CW-1:0] CNT_STEP = CW'(LANES);

  function automatic logic signed [AW-1:0] mul(input logic signed [XW-1:0] x,
                                                input logic signed [AW-1:0] c);
    logic signed [AW-1:0] xe;
    xe = AW'(x);
    return xe * c;
  endfunction

  function automatic logic [DW-1:0] clamp(input logic signed [AW-1:0] s);
    logic [DW-1:0] res;
    if (s[AW-1])
      res = '0;
    else if (|s[AW-2:DW+16])
      res = {DW{1'b1}};
    else
      res = s[DW+15:16];
    return res;
  endfunction

  logic          s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic          s1_full_reg;
  logic          full_range_in;
  logic          ld1, ld2, ld3;
  logic          accept, out_fire, at_last;
  logic [CW-1:0] pix_cnt_reg;
  logic          frame_done_reg;

`ifdef YUV2RGB_FULL_RANGE_EN
  assign full_range_in = full_range;
`else
  assign full_range_in = 1'b0;
`endif

  // Each stage loads when empty or when its successor loads, so bubbles collapse.
  assign ld3      = !s3_valid_reg || out_ready;
  assign ld2      = !s2_valid_reg || ld3;
  assign ld1      = !s1_valid_reg || ld2;
  assign in_ready = clear_n && ld1;
  assign accept   = in_valid && in_ready;
  assign out_fire = s3_valid_reg && out_ready;
  assign at_last  = (pix_cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else begin
      if (ld1) s1_valid_reg <= in_valid;
      if (ld2) s2_valid_reg <= s1_valid_reg;
      if (ld3) s3_valid_reg <= s2_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) s1_full_reg <= full_range_in;
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DW-1:0]        y_in, u_in, v_in;
      logic signed [XW-1:0] y_ofs_next, u_ofs_next, v_ofs_next;
      logic signed [XW-1:0] y1_reg, u1_reg, v1_reg;
      logic signed [AW-1:0] c_y, c_rv, c_gu, c_gv, c_bu;
      logic signed [AW-1:0] py2_reg, prv2_reg, pgu2_reg, pgv2_reg, pbu2_reg;
      logic signed [AW-1:0] r_sum, g_sum, b_sum;
      logic [DW-1:0]        r3_reg, g3_reg, b3_reg;

      assign y_in = in_y[gi*DW +: DW];
      assign u_in = in_u[gi*DW +: DW];
      assign v_in = in_v[gi*DW +: DW];

      // S1: remove offsets; full-range luma keeps its black level at zero
      always_comb begin
        u_ofs_next = $signed({2'b00, u_in}) - C_OFS;
        v_ofs_next = $signed({2'b00, v_in}) - C_OFS;
        if (full_range_in)
          y_ofs_next = $signed({2'b00, y_in});
        else
          y_ofs_next = $signed({2'b00, y_in}) - Y_OFS;
      end

      always_ff @(posedge clk) begin
        if (accept) begin
          y1_reg <= y_ofs_next;
          u1_reg <= u_ofs_next;
          v1_reg <= v_ofs_next;
        end
      end

      // S2: coefficient set follows the range flag captured with the beat
      always_comb begin
        c_y  = CS_Y;
        c_rv = CS_RV;
        c_gu = CS_GU;
        c_gv = CS_GV;
        c_bu = CS_BU;
        if (s1_full_reg) begin
          c_y  = CF_Y;
          c_rv = CF_RV;
          c_gu = CF_GU;
          c_gv = CF_GV;
          c_bu = CF_BU;
        end
      end

      always_ff @(posedge clk) begin
        if (ld2 && s1_valid_reg) begin
          py2_reg  <= mul(y1_reg, c_y);
          prv2_reg <= mul(v1_reg, c_rv);
          pgu2_reg <= mul(u1_reg, c_gu);
          pgv2_reg <= mul(v1_reg, c_gv);
          pbu2_reg <= mul(u1_reg, c_bu);
        end
      end

      // S3: sum and clamp; the output register only moves on a load so stalls hold it
      always_comb begin
        r_sum = py2_reg + prv2_reg;
        g_sum = py2_reg + pgu2_reg + pgv2_reg;
        b_sum = py2_reg + pbu2_reg;
      end

      always_ff @(posedge clk) begin
        if (!clear_n) begin
          r3_reg <= '0;
          g3_reg <= '0;
          b3_reg <= '0;
        end else if (ld3 && s2_valid_reg) begin
          r3_reg <= clamp(r_sum);
          g3_reg <= clamp(g_sum);
          b3_reg <= clamp(b_sum);
        end
      end

      assign out_r[gi*DW +: DW] = r3_reg;
      assign out_g[gi*DW +: DW] = g3_reg;
      assign out_b[gi*DW +: DW] = b3_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      pix_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= out_fire && at_last;
      if (out_fire)
        pix_cnt_reg <= at_last ? '0 : pix_cnt_reg + CNT_STEP;
    end
  end

  assign out_valid  = s3_valid_reg;
  assign out_last   = s3_valid_reg && at_last;
  assign frame_done = frame_done_reg;
  assign pix_cnt    = pix_cnt_reg;

endmodule

// File: tb/tb_yuv_to_rgb_stream.sv
// Bench for yuv_to_rgb_stream: directed vectors, per-cycle comparison against a queue-based
// arithmetic model, and literal expectations for clamps, latency, frame marking and reset.
module tb_yuv_to_rgb_stream;
  localparam int DW = 8;
  localparam int LANES = 2;
  localparam int W = 320;
  localparam int H = 240;
  localparam int CW = 18;
  localparam int FRAME_BEATS = W * H / LANES;
  localparam int LAST = W * H - LANES;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] in_y = '0, in_u = '0, in_v = '0;
  logic in_ready, out_valid, out_last, frame_done;
  logic [15:0] out_r, out_g, out_b;
  logic [CW-1:0] pix_cnt;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
  } px_t;

  px_t exp_q[$];
  int  m_cnt = 0;
  bit  fd_exp = 0;
  bit  stall_prev = 0;
  int  out_beats = 0;
  int  last_at = 0;
  int  fd_count = 0;
  int  cyc = 0;
  bit  toggle_mode = 0;
  int  tog = 0;

  yuv_to_rgb_stream #(.DW(DW), .LANES(LANES), .W(W), .H(H), .CW(CW)) dut (
    .clk(clk), .clear_n(clear_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_u(in_u), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_last(out_last), .frame_done(frame_done), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (toggle_mode) begin
      out_ready = (tog % 3 == 0);
      tog++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic int clampv(input int s);
    if (s < 0) return 0;
    if (s > (256 << 16) - 1) return 255;
    return s / 65536;
  endfunction

  function automatic px_t model(input logic [15:0] y, input logic [15:0] u, input logic [15:0] v);
    px_t p;
    p = '0;
    for (int l = 0; l < LANES; l++) begin
      int yp, up, vp;
      yp = int'(y[l*8 +: 8]) - 16;
      up = int'(u[l*8 +: 8]) - 128;
      vp = int'(v[l*8 +: 8]) - 128;
      p.r[l*8 +: 8] = 8'(clampv(76284 * yp + 104595 * vp));
      p.g[l*8 +: 8] = 8'(clampv(76284 * yp - 25624 * up - 53281 * vp));
      p.b[l*8 +: 8] = 8'(clampv(76284 * yp + 132251 * up));
    end
    return p;
  endfunction

  // Compare process: checks outputs and counters against the model on every cycle.
  always @(negedge clk) begin
    if (!clear_n) begin
      exp_q.delete();
      m_cnt = 0;
      fd_exp = 0;
      stall_prev = 0;
    end else begin
      chk("frame_done", frame_done, fd_exp);
      if (frame_done) fd_count++;
      fd_exp = 0;
      chk("pix_cnt", pix_cnt, m_cnt);
      if (stall_prev) chk("stall_hold_valid", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat got=%0h want=none", out_r);
        end else begin
          chk("out_r", out_r, exp_q[0].r);
          chk("out_g", out_g, exp_q[0].g);
          chk("out_b", out_b, exp_q[0].b);
          chk("out_last", out_last, m_cnt == LAST);
          if (out_ready) begin
            void'(exp_q.pop_front());
            out_beats++;
            if (m_cnt == LAST) begin
              m_cnt = 0;
              fd_exp = 1;
              last_at = out_beats;
            end else begin
              m_cnt += LANES;
            end
          end
        end
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      stall_prev = out_valid && !out_ready;
      if (in_valid && in_ready) exp_q.push_back(model(in_y, in_u, in_v));
    end
  end

  task automatic send(input logic [15:0] y, input logic [15:0] u, input logic [15:0] v);
    int n;
    n = 0;
    in_y = y;
    in_u = u;
    in_v = v;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%0b want=1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
    end
  endtask

  // Right after an accepted beat: out_valid appears on the third cycle with the given data.
  task automatic lat_check(input string name, input logic [15:0] r, input logic [15:0] g,
                           input logic [15:0] b);
    in_valid = 0;
    @(negedge clk);
    chk({name, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_lat2"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_lat3"}, out_valid, 1);
    chk({name, "_r"}, out_r, r);
    chk({name, "_g"}, out_g, g);
    chk({name, "_b"}, out_b, b);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid = 0;
    clear_n = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    px_t pin;
    int  start, c0, c1;

    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_g", out_g, 0);
    chk("rst_out_b", out_b, 0);
    @(posedge clk);
    #1;
    clear_n = 1;

    // Pin the model to hand-computed values
    pin = model(16'h1010, 16'h8080, 16'h8080);
    chk("pin_t1_r", pin.r, 16'h0000);
    pin = model(16'hFFEB, 16'h8080, 16'h8080);
    chk("pin_t2_g", pin.g, 16'hFFFE);
    pin = model(16'h5151, 16'h5A5A, 16'hF0F0);
    chk("pin_t3_r", pin.r, 16'hFEFE);
    chk("pin_t3_g", pin.g, 16'h0000);

    // T1 black, T2 lane0=235 lane1=255, T3 negative clamps
    send(16'h1010, 16'h8080, 16'h8080);
    lat_check("t1", 16'h0000, 16'h0000, 16'h0000);
    send(16'hFFEB, 16'h8080, 16'h8080);
    lat_check("t2", 16'hFFFE, 16'hFFFE, 16'hFFFE);
    send(16'h5151, 16'h5A5A, 16'hF0F0);
    lat_check("t3", 16'hFEFE, 16'h0000, 16'h0000);

    // T4: out_ready 1,0,0,... with input gaps
    start = out_beats;
    tog = 0;
    toggle_mode = 1;
    for (int i = 0; i < 10; i++) begin
      send({8'(30 + i * 19), 8'(20 + i * 23)}, {8'(60 + i * 11), 8'(40 + i * 17)},
           {8'(100 + i * 9), 8'(200 - i * 15)});
      idle(i % 3);
    end
    drain();
    toggle_mode = 0;
    out_ready = 1;
    chk("t4_count", out_beats - start, 10);

    // T5: full frame plus 10 beats of the next, back to back
    pulse_reset();
    start = out_beats;
    fd_count = 0;
    last_at = 0;
    c0 = cyc;
    for (int bt = 0; bt < FRAME_BEATS + 10; bt++)
      send({8'(255 - (bt % 240)), 8'(16 + (bt % 220))}, {8'(bt * 7), 8'(bt * 3)},
           {8'(bt * 13), 8'(255 - (bt % 256))});
    c1 = cyc;
    drain();
    chk("t5_throughput", c1 - c0, FRAME_BEATS + 10);
    chk("t5_last_at", last_at - start, 38400);
    chk("t5_frame_done_cnt", fd_count, 1);
    chk("t5_pix_cnt", pix_cnt, 20);

    // T6: reset mid-stream drops in-flight beats
    for (int i = 0; i < 5; i++) send({8'(50 + i), 8'(60 + i)}, 16'h7090, 16'h9070);
    pulse_reset();
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_pix_cnt", pix_cnt, 0);
    @(posedge clk);
    #1;
    send(16'h5151, 16'h5A5A, 16'hF0F0);
    lat_check("t6", 16'hFEFE, 16'h0000, 16'h0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
